// File: rtl/rtc_alarm_sched_s.sv
// rtc_alarm_sched_s: counts RTC overflow ticks into TIME and fires per-channel alarms
// (one-shot or periodic) onto a single prioritised CPU interrupt, all bus-mapped.
module rtc_alarm_sched_s #(
    parameter int ADDRESS           = 0,
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int CHANNELS          = 4,
    parameter int TIME_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr_w,
    input  logic                         rd_w,
    input  logic [31:0]                  bus_in,
    output logic [31:0]                  bus_out,
    output logic                         req_bus,
    input  logic                         rtc_intr,
    output logic                         rtc_int_rst,
    output logic                         intr,
    output logic [3:0]                   vector,
    input  logic                         int_rst
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT, SCAN} state_t;

    state_t                state;
    logic [3:0]            idx;
    logic [TIME_WIDTH-1:0] time_q;
    logic [CHANNELS-1:0]   enable, pending, ovr, fire, reload_nz, clr, lowest_hit;
    logic [TIME_WIDTH-1:0] alarm  [CHANNELS];
    logic [TIME_WIDTH-1:0] reload [CHANNELS];
    logic [3:0]            lowest;
    logic [31:0]           o, status;
    logic                  wr, busy;

    // Offset wraps to a huge value below ADDRESS, so one compare bounds the window.
    assign o       = 32'(addr) - 32'(ADDRESS);
    assign req_bus = o < 4 + 2 * CHANNELS;
    assign wr      = wr_w && req_bus;
    assign busy    = state != IDLE;
    assign status  = (32'(ovr) << 8) | (32'(busy) << 4) | 32'(vector);

    always_comb begin
        fire       = '0;
        reload_nz  = '0;
        clr        = '0;
        lowest     = '0;
        lowest_hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            reload_nz[k] = reload[k] != '0;
            fire[k] = state == SCAN && idx == 4'(k) && enable[k] && alarm[k] == time_q &&
                      !(wr && (o == 1 || o == 4 + 2 * k || o == 5 + 2 * k));
            clr[k] = (wr && o == 2 && bus_in[k]) || (int_rst && intr && vector == 4'(k));
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            lowest = pending[k] ? 4'(k) : lowest;
        end
    end

    always_comb begin
        bus_out = '0;
        if (req_bus) begin
            bus_out = o == 0 ? 32'(time_q) : o == 1 ? 32'(enable) : o == 2 ? 32'(pending) : o == 3 ? status : '0;
            for (int k = 0; k < CHANNELS; k++) begin
                bus_out = o == 4 + 2 * k ? 32'(alarm[k]) : o == 5 + 2 * k ? 32'(reload[k]) : bus_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            rtc_int_rst <= 1'b0;
            time_q      <= '0;
            enable      <= '0;
            pending     <= '0;
            ovr         <= '0;
            intr        <= 1'b0;
            vector      <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                alarm[k]  <= '0;
                reload[k] <= '0;
            end
        end else begin
            rtc_int_rst <= 1'b0;
            case (state)
                IDLE: if (rtc_intr) begin
                    state       <= ACK;
                    rtc_int_rst <= 1'b1;
                end
                ACK:  state <= WAIT;
                WAIT: if (!rtc_intr) begin
                    state <= SCAN;
                    idx   <= '0;
                end
                SCAN: begin
                    idx   <= idx + 4'd1;
                    state <= idx == 4'(CHANNELS - 1) ? IDLE : SCAN;
                end
                default: state <= IDLE;
            endcase
            if (wr && o == 0)
                time_q <= bus_in[TIME_WIDTH-1:0];
            else if (state == ACK)
                time_q <= time_q + TIME_WIDTH'(1);
            enable  <= wr && o == 1 ? bus_in[CHANNELS-1:0] : enable & ~(fire & ~reload_nz);
            pending <= (pending & ~clr) | fire;
            ovr     <= (rd_w && req_bus && o == 3 ? '0 : ovr) | (fire & pending);
            intr    <= |pending;
            vector  <= lowest;
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr && o == 4 + 2 * k)
                    alarm[k] <= bus_in[TIME_WIDTH-1:0];
                else if (fire[k] && reload_nz[k])
                    alarm[k] <= alarm[k] + reload[k];
                if (wr && o == 5 + 2 * k)
                    reload[k] <= bus_in[TIME_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_rtc_alarm_sched_s.sv
// tb_rtc_alarm_sched_s: directed stimulus pushes expected values into a scoreboard
// queue; a negedge monitor pops and compares whenever a read or probe is presented.
module tb_rtc_alarm_sched_s;
    logic        clk = 0, rst_n = 0, wr_w = 0, rd_w = 0, rtc_intr = 0, int_rst = 0;
    logic [15:0] addr = '0;
    logic [31:0] bus_in = '0, bus_out;
    logic        req_bus, rtc_int_rst, intr;
    logic [3:0]  vector;
    logic        probe = 0;
    int          errors = 0, checks = 0, pulses = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          sel;
    } item_t;
    item_t sb[$];

    rtc_alarm_sched_s dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_w(wr_w), .rd_w(rd_w),
        .bus_in(bus_in), .bus_out(bus_out), .req_bus(req_bus), .rtc_intr(rtc_intr),
        .rtc_int_rst(rtc_int_rst), .intr(intr), .vector(vector), .int_rst(int_rst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rtc_int_rst) pulses++;

    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        if (rd_w || probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", bus_out);
            end else begin
                it  = sb.pop_front();
                act = it.sel == 0 ? bus_out : it.sel == 1 ? 32'(intr) : it.sel == 2 ? 32'(vector) :
                      it.sel == 3 ? 32'(pulses) : 32'(req_bus);
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        addr = 16'(a); bus_in = d; wr_w = 1;
        @(posedge clk); #1;
        wr_w = 0;
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string n);
        @(posedge clk); #1;
        addr = 16'(a); rd_w = 1;
        sb.push_back('{n, e, 0});
        @(posedge clk); #1;
        rd_w = 0;
    endtask

    task automatic chk(input int sel, input logic [31:0] e, input string n);
        @(posedge clk); #1;
        probe = 1;
        sb.push_back('{n, e, sel});
        @(posedge clk); #1;
        probe = 0;
    endtask

    task automatic tick(input int hold);
        @(posedge clk); #1;
        rtc_intr = 1;
        repeat (hold) @(posedge clk);
        #1 rtc_intr = 0;
        repeat (8) @(posedge clk);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        int_rst = 1;
        @(posedge clk); #1;
        int_rst = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        rd(0, 0, "reset_time");
        rd(1, 0, "reset_enable");
        rd(2, 0, "reset_pending");
        rd(3, 0, "reset_status");
        chk(1, 0, "reset_intr");
        chk(2, 0, "reset_vector");
        chk(3, 0, "reset_no_ack_pulse");
        rd(12, 0, "undefined_offset_reads_0");
        chk(4, 0, "req_bus_outside_window");

        // one-shot alarm
        wr(4, 3);
        wr(1, 1);
        repeat (3) tick(2);
        rd(0, 3, "t1_time");
        rd(2, 1, "t1_pending");
        chk(1, 1, "t1_intr");
        chk(2, 0, "t1_vector");
        rd(1, 0, "t1_oneshot_disable");
        ack();
        rd(2, 0, "t1_ack_clears");
        chk(1, 0, "t1_intr_cleared");

        // periodic alarm with overrun
        wr(0, 0);
        wr(6, 2);
        wr(7, 5);
        wr(1, 2);
        repeat (2) tick(2);
        rd(2, 2, "t2_fire_at_2");
        rd(6, 7, "t2_reload_alarm");
        repeat (5) tick(2);
        rd(3, 32'h201, "t2_status_ovr");
        rd(3, 32'h001, "t2_ovr_read_clear");
        repeat (5) tick(2);
        rd(0, 12, "t2_time_12");
        rd(6, 17, "t2_alarm_17");
        wr(1, 0);
        wr(2, 32'hF);
        rd(3, 32'h200, "t2_w1c_status");
        rd(2, 0, "t2_w1c_pending");

        // simultaneous fire, priority and ack sequencing
        wr(0, 0);
        wr(4, 1);
        wr(8, 1);
        wr(1, 5);
        tick(2);
        rd(2, 5, "t3_pending");
        chk(2, 0, "t3_vector0");
        ack();
        chk(2, 2, "t3_vector2");
        chk(1, 1, "t3_intr_still");
        ack();
        chk(1, 0, "t3_intr_cleared");
        rd(1, 0, "t3_enables_cleared");

        // long rtc_intr: one ack pulse, waits in WAIT
        wr(0, 32'h40);
        pulses = 0;
        @(posedge clk); #1;
        rtc_intr = 1;
        repeat (6) @(posedge clk);
        rd(3, 32'h010, "t4_busy_in_wait");
        rtc_intr = 0;
        repeat (8) @(posedge clk);
        chk(3, 1, "t4_single_ack_pulse");
        rd(0, 32'h41, "t4_time_plus1");

        // TIME wrap
        wr(0, 32'hFFFF_FFFF);
        wr(4, 0);
        wr(1, 1);
        tick(2);
        rd(0, 0, "t5_time_wrap");
        rd(2, 1, "t5_fire_at_0");
        chk(1, 1, "t5_intr");

        // reset during SCAN
        @(posedge clk); #1;
        rtc_intr = 1;
        repeat (2) @(posedge clk);
        #1 rtc_intr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk(1, 0, "t6_intr_reset");
        rd(2, 0, "t6_pending_reset");
        rd(0, 0, "t6_time_reset");
        tick(2);
        rd(0, 1, "t6_resume_tick");
        rd(3, 0, "t6_status_idle");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d items left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
